// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: round-robin arbiter granting one shared resource to N four-phase requesters,
// with synchronised asynchronous inputs and a full four-phase cycle on both requester and resource sides.
module rr_handshake_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N-1:0]                       req,
  output logic [N-1:0]                       ack,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_id,
  output logic                               busy,
  output logic                               res_req,
  input  logic                               res_ack
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RES_UP, HOLD, RES_DN} state_t;
  state_t state, state_n;
  logic [N-1:0] req_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ack_pipe;
  logic [N-1:0] req_s, ack_n;
  logic res_ack_s, res_req_n, busy_n;
  logic [W-1:0] ptr, ptr_n, win, grant_id_n;
  function automatic logic [W-1:0] wrap(input int v);
    return W'(v >= N ? v - N : v);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) req_pipe[i] <= '0;
      ack_pipe <= '0;
    end else begin
      req_pipe[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) req_pipe[i] <= req_pipe[i-1];
      ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], res_ack};
    end
  assign req_s     = req_pipe[SYNC_STAGES-1];
  assign res_ack_s = ack_pipe[SYNC_STAGES-1];
  // Scanning backwards leaves the first hit in ptr order as the winner.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_s[wrap(int'(ptr) + k)]) win = wrap(int'(ptr) + k);
  end
  always_comb begin
    state_n    = state;
    ack_n      = ack;
    res_req_n  = res_req;
    grant_id_n = grant_id;
    busy_n     = busy;
    ptr_n      = ptr;
    case (state)
      IDLE:
        if (|req_s) begin
          grant_id_n = win;
          res_req_n  = 1'b1;
          busy_n     = 1'b1;
          state_n    = RES_UP;
        end
      RES_UP:
        if (res_ack_s) begin
          if (req_s[grant_id]) begin
            ack_n[grant_id] = 1'b1;
            state_n         = HOLD;
          end else begin
            res_req_n = 1'b0;
            state_n   = RES_DN;
          end
        end
      HOLD:
        if (!req_s[grant_id]) begin
          ack_n     = '0;
          res_req_n = 1'b0;
          state_n   = RES_DN;
        end
      RES_DN:
        if (!res_ack_s) begin
          ptr_n   = (grant_id == W'(N - 1)) ? '0 : grant_id + W'(1);
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= '0;
      res_req  <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
    end else begin
      state    <= state_n;
      ack      <= ack_n;
      res_req  <= res_req_n;
      grant_id <= grant_id_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
    end
endmodule
